// File: rtl/oc15_pkg.sv
// Shared types and the line-decode function for the 15-line code decoder/encoder pair.
// decode_lines doubles as the golden model in the encoder bench.
package oc15_pkg;

  localparam int unsigned CODE_W = 4;
  localparam int unsigned LINES  = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_e;

  // code 0 decodes to all-zero lines in both modes
  function automatic logic [LINES-1:0] decode_lines(input logic [CODE_W-1:0] code,
                                                    input logic              thermo);
    logic [LINES-1:0] lines;
    lines = '0;
    for (int unsigned i = 0; i < LINES; i++) begin
      if (thermo) lines[i] = (CODE_W'(i) < code);
      else        lines[i] = (code == CODE_W'(i + 1));
    end
    return lines;
  endfunction

endpackage

// File: rtl/oc15_hold_timer.sv
// Loadable 8-bit down-counter that saturates at zero; times the hold and gap windows.
module oc15_hold_timer (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  input  logic       i_dec,
  output logic       o_zero
);

  logic [7:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/oc15_code_decoder.sv
// Registered 4-bit code to 15-line decoder: one code per handshake, driven for a hold
// window, blanked for a gap window, then a one-cycle done pulse back in IDLE.
module oc15_code_decoder
  import oc15_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter bit          THERMO      = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_in_valid,
  input  logic [CODE_W-1:0] i_in_code,
  output logic              o_in_ready,
  output logic [LINES-1:0]  o_y,
  output logic              o_busy,
  output logic              o_done
);

  if ((HOLD_CYCLES < 1) || (HOLD_CYCLES > 255)) begin : g_bad_hold
    $error("oc15_code_decoder: HOLD_CYCLES out of range 1..255");
  end
  if (GAP_CYCLES > 255) begin : g_bad_gap
    $error("oc15_code_decoder: GAP_CYCLES out of range 0..255");
  end

  localparam logic [7:0] HoldLoad = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GapLoad  = 8'(GAP_CYCLES - 1);
  localparam bit         HasGap   = (GAP_CYCLES > 0);

  state_e           r_state;
  logic [LINES-1:0] r_y;
  logic             r_busy;
  logic             r_done;

  logic       w_accept;
  logic       w_load;
  logic [7:0] w_load_val;
  logic       w_dec;
  logic       w_zero;

  assign o_in_ready = i_rst_n && (r_state == IDLE);
  assign w_accept   = i_in_valid && o_in_ready;

  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    w_dec      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_load     = 1'b1;
          w_load_val = HoldLoad;
        end
      end
      HOLD: begin
        if (w_zero && HasGap) begin
          w_load     = 1'b1;
          w_load_val = GapLoad;
        end else begin
          w_dec = 1'b1;
        end
      end
      GAP:     w_dec = 1'b1;
      default: w_dec = 1'b0;
    endcase
  end

  oc15_hold_timer u_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_y     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= HOLD;
            r_y     <= decode_lines(i_in_code, THERMO);
            r_busy  <= 1'b1;
          end
        end
        HOLD: begin
          if (w_zero) begin
            r_y <= '0;
            if (HasGap) begin
              r_state <= GAP;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        GAP: begin
          if (w_zero) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_y     <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_y    = r_y;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: tb/tb_oc15_code_decoder.sv
// Drives three decoder configurations from one shared input stream and checks each against
// a timestamp model: outputs follow from the cycle and code of the last accepted handshake.
module tb_oc15_code_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [3:0]  in_code;
  logic [2:0]  rdy, busy, done;
  logic [14:0] y0, y1, y2;
  logic [14:0] ys [3];

  always #5 clk = ~clk;

  // dut 0: one-hot H4/G2, dut 1: thermometer H4/G2, dut 2: one-hot H1/G0
  oc15_code_decoder #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .THERMO(1'b0)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .i_in_code(in_code),
    .o_in_ready(rdy[0]), .o_y(y0), .o_busy(busy[0]), .o_done(done[0]));
  oc15_code_decoder #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .THERMO(1'b1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .i_in_code(in_code),
    .o_in_ready(rdy[1]), .o_y(y1), .o_busy(busy[1]), .o_done(done[1]));
  oc15_code_decoder #(.HOLD_CYCLES(1), .GAP_CYCLES(0), .THERMO(1'b0)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .i_in_code(in_code),
    .o_in_ready(rdy[2]), .o_y(y2), .o_busy(busy[2]), .o_done(done[2]));

  assign ys[0] = y0;
  assign ys[1] = y1;
  assign ys[2] = y2;

  int         hold_c [3] = '{4, 4, 1};
  int         gap_c  [3] = '{2, 2, 0};
  bit         thermo [3] = '{1'b0, 1'b1, 1'b0};
  int         acc_cyc [3] = '{-1, -1, -1};
  logic [3:0] acc_code [3];
  int         cyc   = 0;
  bit         armed = 1'b0;
  int         total = 0;
  int         bad   = 0;

  function automatic logic [14:0] ref_decode(input bit th, input logic [3:0] c);
    int unsigned v;
    if (th)          v = (32'd1 << c) - 32'd1;
    else if (c == 0) v = 0;
    else             v = 32'd1 << (c - 1);
    return 15'(v);
  endfunction

  // One clock cycle: drive inputs, check every DUT against the model, then record handshakes.
  task automatic step(input logic r, input logic v, input logic [3:0] c);
    int          d;
    bit          act, in_hold, in_win;
    logic [14:0] e_y;
    logic        e_busy, e_done, e_rdy;
    @(posedge clk);
    #1;
    rst_n    = r;
    in_valid = v;
    in_code  = c;
    #1;
    for (int k = 0; k < 3; k++) begin
      act     = (acc_cyc[k] >= 0);
      d       = cyc - acc_cyc[k];
      in_hold = act && (d >= 1) && (d <= hold_c[k]);
      in_win  = act && (d >= 1) && (d <= hold_c[k] + gap_c[k]);
      e_y     = in_hold ? ref_decode(thermo[k], acc_code[k]) : 15'h0;
      e_busy  = in_win;
      e_done  = act && (d == hold_c[k] + gap_c[k] + 1);
      e_rdy   = r && !in_win;
      if (armed) begin
        total++;
        assert (ys[k] === e_y) else begin
          bad++;
          $error("FAIL y dut%0d cyc%0d got %h exp %h", k, cyc, ys[k], e_y);
        end
        total++;
        assert (busy[k] === e_busy) else begin
          bad++;
          $error("FAIL busy dut%0d cyc%0d got %b exp %b", k, cyc, busy[k], e_busy);
        end
        total++;
        assert (done[k] === e_done) else begin
          bad++;
          $error("FAIL done dut%0d cyc%0d got %b exp %b", k, cyc, done[k], e_done);
        end
      end
      total++;
      assert (rdy[k] === e_rdy) else begin
        bad++;
        $error("FAIL ready dut%0d cyc%0d got %b exp %b", k, cyc, rdy[k], e_rdy);
      end
      if (!r) begin
        acc_cyc[k] = -1;
      end else if (v && e_rdy) begin
        acc_cyc[k]  = cyc;
        acc_code[k] = c;
      end
    end
    if (!r) armed = 1'b1;
    cyc++;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_code  = 4'd0;
    // reset held with in_valid high
    repeat (3) step(1'b0, 1'b1, 4'd5);
    // single code 5, code changes while busy must be ignored
    step(1'b1, 1'b1, 4'd5);
    repeat (8) step(1'b1, 1'b0, 4'($urandom));
    // code 15 then code 0 (full sequence with y=0)
    step(1'b1, 1'b1, 4'd15);
    repeat (7) step(1'b1, 1'b0, 4'($urandom));
    step(1'b1, 1'b1, 4'd0);
    repeat (7) step(1'b1, 1'b0, 4'($urandom));
    // valid held high while the code streams 1,2,3
    for (int i = 0; i < 21; i++) step(1'b1, 1'b1, 4'(1 + (i / 7)));
    // back-to-back 15 then 1
    step(1'b1, 1'b1, 4'd15);
    repeat (2) step(1'b1, 1'b1, 4'd1);
    repeat (8) step(1'b1, 1'b0, 4'd0);
    // reset in the second hold cycle, then a fresh accept
    step(1'b1, 1'b1, 4'd9);
    step(1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b0, 4'd0);
    step(1'b1, 1'b1, 4'd3);
    repeat (8) step(1'b1, 1'b0, 4'd0);
    // random traffic with sporadic resets
    repeat (500) step(($urandom % 40) != 0, 1'($urandom), 4'($urandom));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
